// File: rtl/board_pkg.sv
// Shared board geometry, colour type, scanner states and the row-slice rule.
package board_pkg;

  localparam int unsigned BOARD_ROWS  = 8;
  localparam int unsigned BOARD_COLS  = 8;
  localparam int unsigned BOARD_CELLS = BOARD_ROWS * BOARD_COLS;
  localparam int unsigned ROW_W       = 3;
  localparam int unsigned COL_W       = 3;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_FIN
  } scan_state_t;

  // Row r occupies cells[8r+7:8r]; bit c of the slice is column c.
  function automatic logic [BOARD_COLS-1:0] row_slice(
    input logic [BOARD_CELLS-1:0] cells,
    input logic [ROW_W-1:0]       row
  );
    return cells[{row, 3'b000} +: BOARD_COLS];
  endfunction

endpackage

// File: rtl/board_scanner_row_mux.sv
// Combinational row read port of the cell board: rd_row selects one 8-bit row.
module board_row_mux
  import board_pkg::*;
(
  input  logic [BOARD_CELLS-1:0] cells,
  input  logic [ROW_W-1:0]       rd_row,
  output logic [BOARD_COLS-1:0]  rd_val
);

  assign rd_val = row_slice(cells, rd_row);

endmodule

// File: rtl/board_scanner.sv
// Fetches the 8x8 board row by row and streams every cell as CELL_PX x CELL_PX
// pixel beats (x, y, colour) over a valid/ready handshake.
module board_scanner
  import board_pkg::*;
#(
  parameter int unsigned CELL_PX      = 4,
  parameter int unsigned X_W          = 8,
  parameter colour_t     ALIVE_COLOUR = 3'b111,
  parameter colour_t     DEAD_COLOUR  = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ROW_W-1:0]      rd_row,
  input  logic [BOARD_COLS-1:0] rd_val,
  output logic                  plot_valid,
  input  logic                  plot_ready,
  output logic [X_W-1:0]        plot_x,
  output logic [X_W-1:0]        plot_y,
  output colour_t               plot_colour,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SH   = $clog2(CELL_PX);
  localparam int unsigned PX_W = (SH == 0) ? 1 : SH;
  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(CELL_PX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BOARD_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BOARD_ROWS - 1);

  scan_state_t           state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [PX_W-1:0]       px_q, px_d;
  logic [PX_W-1:0]       py_q, py_d;
  logic [BOARD_COLS-1:0] buf_q, buf_d;
  logic [X_W-1:0]        x_d, y_d;
  colour_t               colour_d;

  // Next state, pixel counters (px innermost, then col, then py) and output values.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    px_d    = px_q;
    py_d    = py_q;
    buf_d   = buf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          row_d   = '0;
          col_d   = '0;
          px_d    = '0;
          py_d    = '0;
        end
      end
      ST_FETCH: begin
        buf_d   = rd_val;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (plot_valid && plot_ready) begin
          if (px_q != PX_LAST) begin
            px_d = px_q + PX_W'(1);
          end else begin
            px_d = '0;
            if (col_q != COL_LAST) begin
              col_d = col_q + COL_W'(1);
            end else begin
              col_d = '0;
              if (py_q != PX_LAST) begin
                py_d = py_q + PX_W'(1);
              end else begin
                py_d = '0;
                if (row_q == ROW_LAST) begin
                  state_d = ST_FIN;
                end else begin
                  row_d   = row_q + ROW_W'(1);
                  state_d = ST_FETCH;
                end
              end
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    x_d      = (X_W'(col_d) << SH) + X_W'(px_d);
    y_d      = (X_W'(row_d) << SH) + X_W'(py_d);
    colour_d = buf_d[col_d] ? ALIVE_COLOUR : DEAD_COLOUR;
  end

  // State, counters, row snapshot and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      buf_q       <= '0;
      rd_row      <= '0;
      plot_valid  <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= DEAD_COLOUR;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      px_q        <= px_d;
      py_q        <= py_d;
      buf_q       <= buf_d;
      rd_row      <= row_d;
      plot_valid  <= (state_d == ST_EMIT);
      plot_x      <= x_d;
      plot_y      <= y_d;
      plot_colour <= colour_d;
      busy        <= (state_d != ST_IDLE);
      done        <= (state_d == ST_FIN);
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// Bench for board_scanner: two instances (CELL_PX=1 and CELL_PX=2), each fed by a
// board_row_mux, checked every cycle against a beat-index model of the scan.
module tb_board_scanner;
  import board_pkg::*;

  localparam colour_t ALIVE = 3'b111;
  localparam colour_t DEAD  = 3'b000;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        start;
  logic [1:0]        ready;
  logic [1:0][63:0]  cells;
  logic [1:0][2:0]   rd_row;
  logic [1:0][7:0]   rd_val;
  logic [1:0]        valid, busy, done;
  logic [1:0][7:0]   ox, oy;
  logic [1:0][2:0]   ocol;

  board_row_mux u_mux0 (.cells(cells[0]), .rd_row(rd_row[0]), .rd_val(rd_val[0]));
  board_row_mux u_mux1 (.cells(cells[1]), .rd_row(rd_row[1]), .rd_val(rd_val[1]));

  board_scanner #(.CELL_PX(1), .X_W(8), .ALIVE_COLOUR(ALIVE), .DEAD_COLOUR(DEAD)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .rd_row(rd_row[0]), .rd_val(rd_val[0]),
    .plot_valid(valid[0]), .plot_ready(ready[0]), .plot_x(ox[0]), .plot_y(oy[0]),
    .plot_colour(ocol[0]), .busy(busy[0]), .done(done[0]));

  board_scanner #(.CELL_PX(2), .X_W(8), .ALIVE_COLOUR(ALIVE), .DEAD_COLOUR(DEAD)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .rd_row(rd_row[1]), .rd_val(rd_val[1]),
    .plot_valid(valid[1]), .plot_ready(ready[1]), .plot_x(ox[1]), .plot_y(oy[1]),
    .plot_colour(ocol[1]), .busy(busy[1]), .done(done[1]));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h", id, name, act, exp);
    end
  endtask

  int cp [2] = '{1, 2};

  function automatic int bpr(input int i);
    return 8 * cp[i] * cp[i];
  endfunction

  // Model: a scan is 64*CP^2 beats; each row starts with a one-cycle fetch.
  bit        m_act [2];
  bit        m_fetch [2];
  bit        m_fin [2];
  int        m_k [2];
  logic [7:0] m_snap [2];
  int        cyc = 0;
  int        acc_cyc [2];
  // Observed-transfer statistics (only grow).
  int        beats [2];
  int        alive [2];
  int        abox [2];
  int        arow [2][8];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_fetch[i] = 0; m_fin[i] = 0; m_k[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (valid[i] && ready[i]) begin
          beats[i]++;
          if (ocol[i] == ALIVE) begin
            alive[i]++;
            if (int'(oy[i]) / cp[i] < 8) arow[i][int'(oy[i]) / cp[i]]++;
            if (ox[i] >= 8'd14 && oy[i] >= 8'd14) abox[i]++;
          end
        end
        if (m_fin[i]) begin
          m_fin[i] = 0;
        end else if (!m_act[i]) begin
          if (start[i]) begin
            m_act[i] = 1; m_fetch[i] = 1; m_k[i] = 0; acc_cyc[i] = cyc;
          end
        end else if (m_fetch[i]) begin
          m_snap[i]  = cells[i][8*(m_k[i]/bpr(i)) +: 8];
          m_fetch[i] = 0;
        end else if (ready[i]) begin
          m_k[i]++;
          if (m_k[i] == 64 * cp[i] * cp[i]) begin
            m_act[i] = 0; m_fin[i] = 1;
          end else if (m_k[i] % bpr(i) == 0) begin
            m_fetch[i] = 1;
          end
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every non-reset cycle.
  bit        pv [2];
  logic [7:0] sx [2], sy [2];
  logic [2:0] sc [2];
  int        first_lat [2], done_lat [2], dcnt [2];
  logic [7:0] fx [2], fy [2];
  logic [2:0] fc [2];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      pv[0] = 0; pv[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int w, er, epy, ecol, epx;
        bit ev;
        ev = m_act[i] && !m_fetch[i];
        chk("plot_valid", i, valid[i], ev);
        chk("busy", i, busy[i], m_act[i] || m_fin[i]);
        chk("done", i, done[i], m_fin[i]);
        if (m_act[i] && m_fetch[i]) chk("rd_row", i, rd_row[i], m_k[i] / bpr(i));
        if (ev) begin
          er   = m_k[i] / bpr(i);
          w    = m_k[i] % bpr(i);
          epy  = w / (8 * cp[i]);
          ecol = (w % (8 * cp[i])) / cp[i];
          epx  = w % cp[i];
          chk("plot_x", i, ox[i], ecol * cp[i] + epx);
          chk("plot_y", i, oy[i], er * cp[i] + epy);
          chk("plot_colour", i, ocol[i], m_snap[i][ecol] ? ALIVE : DEAD);
        end
        if (pv[i] && !ready[i]) begin
          chk("hold_x", i, ox[i], sx[i]);
          chk("hold_y", i, oy[i], sy[i]);
          chk("hold_colour", i, ocol[i], sc[i]);
        end
        if (valid[i] && !pv[i] && m_k[i] == 0) begin
          first_lat[i] = cyc - acc_cyc[i];
          fx[i] = ox[i]; fy[i] = oy[i]; fc[i] = ocol[i];
        end
        if (done[i]) begin
          done_lat[i] = cyc - acc_cyc[i];
          dcnt[i]++;
        end
        pv[i] = valid[i]; sx[i] = ox[i]; sy[i] = oy[i]; sc[i] = ocol[i];
      end
    end
  end

  // Baselines for per-scan deltas.
  int bb [2], ba [2], bx [2], bd [2];
  int br [2][8];

  task automatic mark();
    for (int i = 0; i < 2; i++) begin
      bb[i] = beats[i]; ba[i] = alive[i]; bx[i] = abox[i]; bd[i] = dcnt[i];
      for (int r = 0; r < 8; r++) br[i][r] = arow[i][r];
    end
  endtask

  task automatic drive(input int mode, input int n, input bit noise);
    case (mode)
      0: ready = 2'b11;
      1: ready = (n % 4 == 0 || n % 4 == 3) ? 2'b11 : 2'b00;
      default: ready = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
    endcase
    start = '0;
    if (noise) begin
      for (int i = 0; i < 2; i++) begin
        int idx;
        if (busy[i] && $urandom_range(0, 15) == 0) start[i] = 1'b1;
        if ($urandom_range(0, 7) == 0) begin
          idx = int'($urandom_range(0, 63));
          cells[i][idx] = ~cells[i][idx];
        end
      end
    end
  endtask

  task automatic run(input logic [1:0] which, input int mode, input bit noise, input bit snap);
    int  n;
    bit  wrote;
    wrote = 0;
    @(negedge clk); #1;
    drive(mode, 0, 0);
    start = which;
    n = 1;
    do begin
      @(negedge clk); #1;
      drive(mode, n, noise);
      n++;
      if (snap && !wrote && beats[0] - bb[0] >= 1) begin
        cells[0][7:0]   = 8'hFF;
        cells[0][47:40] = 8'hFF;
        wrote = 1;
      end
    end while (busy != 2'b00 && n < 3000);
    chk("scan_timeout", 0, busy, 0);
    if (busy != 2'b00) begin
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = '0;
    ready = '0;
    cells = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_rd_row", i, rd_row[i], 0);
      chk("rst_valid", i, valid[i], 0);
      chk("rst_busy", i, busy[i], 0);
      chk("rst_done", i, done[i], 0);
      chk("rst_x", i, ox[i], 0);
      chk("rst_y", i, oy[i], 0);
      chk("rst_colour", i, ocol[i], DEAD);
    end
    #1 reset = 1'b0;

    // Single alive cell at (0,0) on CP=1; single alive cell at (7,7) on CP=2.
    cells[0] = 64'h0000_0000_0000_0001;
    cells[1] = 64'h8000_0000_0000_0000;
    mark();
    run(2'b11, 0, 0, 0);
    chk("t1_first_lat", 0, first_lat[0], 1);
    chk("t1_first_x", 0, fx[0], 0);
    chk("t1_first_y", 0, fy[0], 0);
    chk("t1_first_colour", 0, fc[0], ALIVE);
    chk("t1_done_lat", 0, done_lat[0], 72);
    chk("t1_beats", 0, beats[0] - bb[0], 64);
    chk("t1_alive", 0, alive[0] - ba[0], 1);
    chk("t1_done_cnt", 0, dcnt[0] - bd[0], 1);
    chk("t1_first_lat", 1, first_lat[1], 1);
    chk("t1_done_lat", 1, done_lat[1], 264);
    chk("t1_beats", 1, beats[1] - bb[1], 256);
    chk("t1_alive", 1, alive[1] - ba[1], 4);
    chk("t1_alive_box", 1, abox[1] - bx[1], 4);

    // Backpressure with ready pattern 1,0,0,1 on random boards.
    cells[0] = {$urandom, $urandom};
    cells[1] = {$urandom, $urandom};
    mark();
    run(2'b11, 1, 0, 0);
    chk("bp_beats", 0, beats[0] - bb[0], 64);
    chk("bp_beats", 1, beats[1] - bb[1], 256);
    chk("bp_alive", 0, alive[0] - ba[0], $countones(cells[0]));
    chk("bp_alive", 1, alive[1] - ba[1], 4 * $countones(cells[1]));
    chk("bp_done_cnt", 0, dcnt[0] - bd[0], 1);
    chk("bp_done_cnt", 1, dcnt[1] - bd[1], 1);

    // Snapshot: rows 0 and 5 rewritten to FF during row 0 emission.
    cells[0] = 64'h0000_0000_0000_005A;
    mark();
    run(2'b01, 0, 0, 1);
    chk("snap_row0_alive", 0, arow[0][0] - br[0][0], 4);
    chk("snap_row5_alive", 0, arow[0][5] - br[0][5], 8);
    chk("snap_alive_total", 0, alive[0] - ba[0], 12);

    // Random boards, random ready, mid-scan starts and board writes.
    repeat (4) begin
      cells[0] = {$urandom, $urandom};
      cells[1] = {$urandom, $urandom};
      mark();
      run(2'b11, 2, 1, 0);
      chk("rnd_done_cnt", 0, dcnt[0] - bd[0], 1);
      chk("rnd_done_cnt", 1, dcnt[1] - bd[1], 1);
    end

    // Reset at beat 20 with start held high, then a clean restart.
    cells[0] = {$urandom, $urandom};
    mark();
    @(negedge clk); #1;
    ready = 2'b11;
    start = 2'b01;
    n = 0;
    while (beats[0] - bb[0] < 20 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rst20_reached", 0, beats[0] - bb[0], 20);
    start = 2'b00;
    reset = 1'b1;
    #1;
    chk("rst20_valid", 0, valid[0], 0);
    chk("rst20_busy", 0, busy[0], 0);
    chk("rst20_done", 0, done[0], 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    chk("rst20_no_done", 0, dcnt[0] - bd[0], 0);
    cells[0] = 64'h0000_0000_0000_0001;
    mark();
    run(2'b01, 0, 0, 0);
    chk("restart_x", 0, fx[0], 0);
    chk("restart_y", 0, fy[0], 0);
    chk("restart_colour", 0, fc[0], ALIVE);
    chk("restart_beats", 0, beats[0] - bb[0], 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
